// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the write-back source classification used by WB.
// Pure declarations; no timing or backpressure.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [31:0] I_ALL_LOADS = 32'b?????????????????????????0000011;
    localparam logic [31:0] S_ALL       = 32'b?????????????????????????0100011;
    localparam logic [31:0] R_ALL       = 32'b?????????????????????????0110011;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_ALU,
        WB_SRC_LINK,
        WB_SRC_LOAD
    } wb_src_e;

    function automatic wb_src_e wb_src_of(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: wb_src_of = WB_SRC_ALU;
            OPC_JAL, OPC_JALR:                      wb_src_of = WB_SRC_LINK;
            OPC_LOAD:                               wb_src_of = WB_SRC_LOAD;
            default:                                wb_src_of = WB_SRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/writeback_if.sv
// MEM->WB inputs plus the regfile write port and retire status of the WB stage.
// slave = WB stage, master = surrounding pipeline / bench.
interface writeback_if #(
    parameter int CNT_W = 64
);
    logic             valid_i;
    logic [31:0]      instr_i;
    logic [31:0]      pc_i;
    logic [31:0]      alu_result_i;
    logic [31:0]      mem_rdata_i;
    logic             stall_i;
    logic             flush_i;
    logic             rd_we_o;
    logic [4:0]       rd_sel_o;
    logic [31:0]      rd_data_o;
    logic             misalign_o;
    logic [CNT_W-1:0] instret_o;

    modport slave (
        input  valid_i, instr_i, pc_i, alu_result_i, mem_rdata_i, stall_i, flush_i,
        output rd_we_o, rd_sel_o, rd_data_o, misalign_o, instret_o
    );

    modport master (
        output valid_i, instr_i, pc_i, alu_result_i, mem_rdata_i, stall_i, flush_i,
        input  rd_we_o, rd_sel_o, rd_data_o, misalign_o, instret_o
    );
endinterface

// File: rtl/load_align.sv
// Extracts and extends a byte/half/word from a word-aligned read; flags misalignment.
// Combinational, no backpressure.
module load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data,
    output logic        misaligned,
    output logic        illegal
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = word[{offset, 3'b000} +: 8];
        half_v     = offset[1] ? word[31:16] : word[15:0];
        data       = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_v[7]}}, byte_v};
            F3_LBU: data = {24'b0, byte_v};
            F3_LH: begin
                data       = {{16{half_v[15]}}, half_v};
                misaligned = offset[0];
            end
            F3_LHU: begin
                data       = {16'b0, half_v};
                misaligned = offset[0];
            end
            F3_LW: begin
                data       = word;
                misaligned = |offset;
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/writeback.sv
// WB stage: registers the MEM result, drives the regfile write port one cycle later, counts retires.
// stall_i freezes all WB state and suppresses retire; flush_i kills the instruction being captured.
module writeback
    import riscv_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    writeback_if.slave  bus
);
    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_instr_q, wb_instr_d;
    logic [31:0]      wb_pc_q, wb_pc_d;
    logic [31:0]      wb_alu_q, wb_alu_d;
    logic [31:0]      wb_rdata_q, wb_rdata_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic        retire;
    wb_src_e     src;
    logic        writes;
    logic [31:0] wr_data;
    logic [31:0] ld_data;
    logic        ld_mis;
    logic        ld_ill;
    logic [4:0]  rd;

    assign retire = wb_valid_q & ~bus.stall_i;
    assign rd     = wb_instr_q[11:7];

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_instr_d = wb_instr_q;
        wb_pc_d    = wb_pc_q;
        wb_alu_d   = wb_alu_q;
        wb_rdata_d = wb_rdata_q;
        if (!bus.stall_i) begin
            wb_valid_d = bus.valid_i & ~bus.flush_i;
            wb_instr_d = bus.instr_i;
            wb_pc_d    = bus.pc_i;
            wb_alu_d   = bus.alu_result_i;
            wb_rdata_d = bus.mem_rdata_i;
        end
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_instr_q <= '0;
            wb_pc_q    <= '0;
            wb_alu_q   <= '0;
            wb_rdata_q <= '0;
            instret_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_instr_q <= wb_instr_d;
            wb_pc_q    <= wb_pc_d;
            wb_alu_q   <= wb_alu_d;
            wb_rdata_q <= wb_rdata_d;
            instret_q  <= instret_d;
        end
    end

    load_align u_load_align (
        .funct3     (wb_instr_q[14:12]),
        .offset     (wb_alu_q[1:0]),
        .word       (wb_rdata_q),
        .data       (ld_data),
        .misaligned (ld_mis),
        .illegal    (ld_ill)
    );

    // Loads and R-type match the decode-stage patterns; everything else classifies by opcode.
    always_comb begin
        casez (wb_instr_q)
            I_ALL_LOADS: src = WB_SRC_LOAD;
            R_ALL:       src = WB_SRC_ALU;
            default:     src = wb_src_of(wb_instr_q[6:0]);
        endcase
    end

    always_comb begin
        writes  = 1'b0;
        wr_data = '0;
        case (src)
            WB_SRC_ALU: begin
                writes  = 1'b1;
                wr_data = wb_alu_q;
            end
            WB_SRC_LINK: begin
                writes  = 1'b1;
                wr_data = wb_pc_q + 32'd4;
            end
            WB_SRC_LOAD: begin
                writes  = ~ld_mis & ~ld_ill;
                wr_data = ld_data;
            end
            default: begin
                writes  = 1'b0;
                wr_data = '0;
            end
        endcase
    end

    assign bus.rd_we_o    = retire & writes & (rd != 5'd0);
    assign bus.rd_sel_o   = wb_valid_q ? rd : 5'd0;
    assign bus.rd_data_o  = bus.rd_we_o ? wr_data : 32'd0;
    assign bus.misalign_o = retire & (src == WB_SRC_LOAD) & ld_mis;
    assign bus.instret_o  = instret_q;
endmodule
